// File: rtl/seg_scan.sv
// Time-multiplexed scan controller feeding a per-digit 7-segment encoder.
// Snapshots each frame, computes leading-zero blanking and drives guarded active-low anodes.
module seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 500
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [4*DIGITS-1:0]       digits_i,
    input  logic [DIGITS-1:0]         pnt_i,
    input  logic                      lzb_en_i,
    output logic [3:0]                val_o,
    output logic                      pnt_o,
    output logic                      hzero_o,
    output logic [DIGITS-1:0]         an_o,
    output logic [$clog2(DIGITS)-1:0] slot_o
);

    localparam int SW = $clog2(DIGITS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GUARD_C   = DW'(GUARD);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

    logic [DW-1:0]       divCnt_q, divCnt_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic                restart_q, restart_d;
    logic                first_q, first_d;
    logic [4*DIGITS-1:0] snapDig_q, snapDig_d;
    logic [DIGITS-1:0]   snapPnt_q, snapPnt_d;
    logic                snapLzb_q, snapLzb_d;
    logic [3:0]          val_q, val_d;
    logic                pnt_q, pnt_d;
    logic                hzero_q, hzero_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [SW-1:0]       slotOut_q, slotOut_d;

    logic [DW-1:0]     cnt;
    logic              divWrap;
    logic              slotWrap;
    logic              zeroRun;
    logic [DIGITS-1:0] hide;
    logic [DIGITS-1:0] onehot;
    logic [3:0]        digArr [DIGITS];

    // A digit is hidden when it and every more significant digit is zero without a point.
    always_comb begin
        zeroRun = 1'b1;
        hide    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digArr[k] = snapDig_q[4*k +: 4];
            zeroRun   = zeroRun & (snapDig_q[4*k +: 4] == 4'd0) & ~snapPnt_q[k];
            hide[k]   = snapLzb_q & zeroRun & (k != 0);
        end
        onehot         = '0;
        onehot[slot_q] = 1'b1;
    end

    // After a pause the held count is treated as 0 so the slot restarts with a full guard.
    always_comb begin
        cnt      = restart_q ? '0 : divCnt_q;
        divWrap  = (cnt == DIV_LAST);
        slotWrap = (slot_q == SLOT_LAST);

        divCnt_d  = divCnt_q;
        slot_d    = slot_q;
        restart_d = restart_q;
        first_d   = first_q;
        snapDig_d = snapDig_q;
        snapPnt_d = snapPnt_q;
        snapLzb_d = snapLzb_q;
        val_d     = val_q;
        pnt_d     = pnt_q;
        hzero_d   = hzero_q;
        an_d      = an_q;
        slotOut_d = slotOut_q;

        if (en_i) begin
            divCnt_d  = divWrap ? '0 : cnt + 1'b1;
            if (divWrap) begin
                slot_d = slotWrap ? '0 : slot_q + 1'b1;
            end
            restart_d = 1'b0;
            first_d   = 1'b0;
            if (first_q || (divWrap && slotWrap)) begin
                snapDig_d = digits_i;
                snapPnt_d = pnt_i;
                snapLzb_d = lzb_en_i;
            end
            val_d     = digArr[slot_q];
            pnt_d     = snapPnt_q[slot_q];
            hzero_d   = hide[slot_q];
            slotOut_d = slot_q;
            an_d      = (cnt < GUARD_C) ? '1 : ~onehot;
        end else begin
            restart_d = 1'b1;
            an_d      = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divCnt_q  <= '0;
            slot_q    <= '0;
            restart_q <= 1'b0;
            first_q   <= 1'b1;
            snapDig_q <= '0;
            snapPnt_q <= '0;
            snapLzb_q <= 1'b0;
            val_q     <= 4'd0;
            pnt_q     <= 1'b0;
            hzero_q   <= 1'b1;
            an_q      <= '1;
            slotOut_q <= '0;
        end else begin
            divCnt_q  <= divCnt_d;
            slot_q    <= slot_d;
            restart_q <= restart_d;
            first_q   <= first_d;
            snapDig_q <= snapDig_d;
            snapPnt_q <= snapPnt_d;
            snapLzb_q <= snapLzb_d;
            val_q     <= val_d;
            pnt_q     <= pnt_d;
            hzero_q   <= hzero_d;
            an_q      <= an_d;
            slotOut_q <= slotOut_d;
        end
    end

    assign val_o   = val_q;
    assign pnt_o   = pnt_q;
    assign hzero_o = hzero_q;
    assign an_o    = an_q;
    assign slot_o  = slotOut_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: frames are predicted per slot from the blanking rule,
// and a monitor pops one expectation each time an anode turns on.
module tb_seg_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int NFRAMES  = 12;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  pnt;
    logic        lzb;
    logic [3:0]  val_o;
    logic        pnt_o;
    logic        hzero_o;
    logic [3:0]  an_o;
    logic [1:0]  slot_o;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] val;
        logic       pnt;
        logic       hz;
        logic [1:0] slot;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    bit          monOn  = 1'b0;
    logic [15:0] fd [NFRAMES+1];
    logic [3:0]  fp [NFRAMES+1];
    logic        fl [NFRAMES+1];

    seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .digits_i(digits),
        .pnt_i   (pnt),
        .lzb_en_i(lzb),
        .val_o   (val_o),
        .pnt_o   (pnt_o),
        .hzero_o (hzero_o),
        .an_o    (an_o),
        .slot_o  (slot_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected display of slot k: the number is shown from its most significant
    // nonzero-or-pointed digit downwards; everything above is blank when lzb is on.
    function automatic exp_t refSlot(input logic [15:0] d, input logic [3:0] p, input logic l, input int k);
        exp_t e;
        int   msd = -1;
        for (int j = 0; j < DIGITS; j++)
            if (d[4*j +: 4] != 4'd0 || p[j]) msd = j;
        e.an    = 4'hF;
        e.an[k] = 1'b0;
        e.val   = d[4*k +: 4];
        e.pnt   = p[k];
        e.hz    = l && (k != 0) && (k > msd);
        e.slot  = 2'(k);
        return e;
    endfunction

    task automatic pushFrame(input int m);
        for (int k = 0; k < DIGITS; k++)
            expQ.push_back(refSlot(fd[m], fp[m], fl[m], k));
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic l);
        digits = d;
        pnt    = p;
        lzb    = l;
    endtask

    task automatic doReset(input logic [15:0] d);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        applyStimulus(d, 4'h0, 1'b0);
    endtask

    // Monitor: a new slot presentation starts when any anode turns on.
    bit   prevActive = 1'b0;
    bit   seenFirst  = 1'b0;
    int   onLen      = 0;
    int   offLen     = 0;
    exp_t got;
    exp_t want;
    always @(negedge clk) begin
        if (monOn) begin
            if (an_o != 4'hF) begin
                if (!prevActive) begin
                    if (seenFirst) checkOutput("guardLen", offLen, GUARD);
                    seenFirst = 1'b1;
                    got = '{an_o, val_o, pnt_o, hzero_o, slot_o};
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedSlot", got, 0);
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("an",    got.an,   want.an);
                        checkOutput("val",   got.val,  want.val);
                        checkOutput("pnt",   got.pnt,  want.pnt);
                        checkOutput("hzero", got.hz,   want.hz);
                        checkOutput("slot",  got.slot, want.slot);
                    end
                    onLen = 0;
                end
                onLen++;
                prevActive = 1'b1;
            end else begin
                if (prevActive) begin
                    checkOutput("activeLen", onLen, SCAN_DIV - GUARD);
                    offLen = 0;
                end
                offLen++;
                prevActive = 1'b0;
            end
        end
    end

    logic [15:0] masks [5];

    initial begin
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        fd[0] = 16'h1234; fp[0] = 4'h0;    fl[0] = 1'b0;
        fd[1] = 16'h0045; fp[1] = 4'h0;    fl[1] = 1'b1;
        fd[2] = 16'h0045; fp[2] = 4'h0;    fl[2] = 1'b0;
        fd[3] = 16'h0000; fp[3] = 4'b0100; fl[3] = 1'b1;
        fd[4] = 16'h0000; fp[4] = 4'h0;    fl[4] = 1'b1;
        fd[5] = 16'h1111; fp[5] = 4'h0;    fl[5] = 1'b1;
        fd[6] = 16'h2222; fp[6] = 4'h0;    fl[6] = 1'b1;
        for (int m = 7; m <= NFRAMES; m++) begin
            fd[m] = 16'($urandom) & masks[$urandom_range(4, 0)];
            fp[m] = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
            fl[m] = 1'($urandom);
        end

        rst = 1'b1;
        en  = 1'b0;
        applyStimulus(16'h0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstAn",    an_o,    4'hF);
        checkOutput("rstVal",   val_o,   4'h0);
        checkOutput("rstPnt",   pnt_o,   1'b0);
        checkOutput("rstHzero", hzero_o, 1'b1);
        checkOutput("rstSlot",  slot_o,  2'd0);

        // Frame m must be on the inputs at enabled edge FRAME*m-1 (edge 0 for frame 0);
        // all other edges see garbage that must never reach the display.
        rst = 1'b0;
        en  = 1'b1;
        applyStimulus(fd[0], fp[0], fl[0]);
        pushFrame(0);
        monOn = 1'b1;
        for (int e = 1; e <= FRAME * (NFRAMES + 1) - 2; e++) begin
            @(negedge clk);
            if ((e + 1) % FRAME == 0) begin
                applyStimulus(fd[(e + 1) / FRAME], fp[(e + 1) / FRAME], fl[(e + 1) / FRAME]);
                pushFrame((e + 1) / FRAME);
            end else begin
                applyStimulus(16'($urandom), 4'($urandom), 1'($urandom));
            end
        end
        @(negedge clk);
        monOn = 1'b0;
        checkOutput("queueDrained", expQ.size(), 0);

        // Pause in the middle of slot 2, then resume.
        doReset(16'h5678);
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checkOutput("pauseAn",   an_o,   4'hF);
        checkOutput("pauseSlot", slot_o, 2'd2);
        repeat (3) @(negedge clk);
        checkOutput("pauseHoldAn",   an_o,   4'hF);
        checkOutput("pauseHoldSlot", slot_o, 2'd2);
        checkOutput("pauseHoldVal",  val_o,  4'h6);
        en = 1'b1;
        @(negedge clk);
        checkOutput("resumeGuard0", an_o, 4'hF);
        @(negedge clk);
        checkOutput("resumeGuard1", an_o, 4'hF);
        @(negedge clk);
        checkOutput("resumeAn",  an_o,  4'b1011);
        checkOutput("resumeVal", val_o, 4'h6);

        // Reset pulse at count 5 of slot 3 aborts the scan.
        doReset(16'h90A3);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstAn",    an_o,    4'hF);
        checkOutput("midRstSlot",  slot_o,  2'd0);
        checkOutput("midRstVal",   val_o,   4'h0);
        checkOutput("midRstHzero", hzero_o, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("restartGuard0", an_o, 4'hF);
        @(negedge clk);
        checkOutput("restartGuard1", an_o, 4'hF);
        @(negedge clk);
        checkOutput("restartAn",   an_o,   4'b1110);
        checkOutput("restartVal",  val_o,  4'h3);
        checkOutput("restartSlot", slot_o, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
